full_adder_core: RTL and testbench

- Clocked, parameterizable ripple-carry adder built from 1-bit full-adder cells.
- Sums a, b and carry_in, producing registered result and carry_out one cycle later.
- At WIDTH=1 it is the team's basic full-adder primitive, wrapped with a valid pipeline stage.
- It is the arithmetic building block for the ALU datapath.

---
 rtl/full_adder_core.sv | 79 +++++++
 tb/tb_full_adder_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_core.sv
// full_adder_core: registered ripple-carry adder built from 1-bit full-adder cells.
// Computes {carry_out, result} = a + b + carry_in and registers it with a latency of one clk.
// Optional feature macro FULL_ADDER_OVF_EN adds a registered signed-overflow output.
//
// Valid semantics: in_valid qualifies a, b and carry_in for the current rising edge. There is
// no ready/backpressure, so every in_valid beat is accepted. out_valid is high for exactly the
// cycle after a capture. While in_valid is low, the registered result/carry_out (and overflow)
// hold their last captured values and the operand inputs are ignored entirely.
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
`ifdef FULL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  // One full-adder cell: returns {carry_next, sum_bit}.
  function automatic logic [1:0] fa_cell(input logic ai, input logic bi, input logic ci);
    logic p;
    p = ai ^ bi;
    return {(ai & bi) | (ci & p), p ^ ci};
  endfunction

  // Ripple the carry from bit 0 up to the MSB, one cell per bit.
  always_comb begin
    carry    = '0;
    sum_comb = '0;
    carry[0] = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      {carry[i+1], sum_comb[i]} = fa_cell(a[i], b[i], carry[i]);
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  // At WIDTH=1, carry[0] is carry_in, so this reduces to carry_out ^ carry_in.
  logic ovf_comb;

  // Derive signed overflow from the top two carries of the chain.
  always_comb begin
    ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];
  end
`endif

  // Output stage: capture the sum on in_valid, otherwise hold; async reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= sum_comb;
        carry_out <= carry[WIDTH];
`ifdef FULL_ADDER_OVF_EN
        overflow  <= ovf_comb;
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: checks full_adder_core at WIDTH=1 and WIDTH=8 side by side.
// An arithmetic reference model tracks the expected registered outputs; a compare loop checks
// both instances on every falling edge, and directed vectors carry hand-computed literals.
module tb_full_adder_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       iv = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       c1 = 1'b0;

  // ---------------- DUT outputs ----------------
  logic       u8_ov, u8_co, u8_ovf;
  logic [7:0] u8_res;
  logic       u1_ov, u1_co, u1_ovf;
  logic [0:0] u1_res;

  full_adder_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a8), .b(b8), .carry_in(c8),
    .out_valid(u8_ov), .result(u8_res),
`ifdef FULL_ADDER_OVF_EN
    .overflow(u8_ovf),
`endif
    .carry_out(u8_co)
  );

  full_adder_core #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv), .a(a1), .b(b1), .carry_in(c1),
    .out_valid(u1_ov), .result(u1_res),
`ifdef FULL_ADDER_OVF_EN
    .overflow(u1_ovf),
`endif
    .carry_out(u1_co)
  );

`ifndef FULL_ADDER_OVF_EN
  assign u8_ovf = 1'b0;
  assign u1_ovf = 1'b0;
`endif

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned sum for result/carry, signed range test for overflow.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int u, s;
    u = int'(a) + int'(b) + int'(c);
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return {(s > 127 || s < -128), u[8:0]};
  endfunction

  function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
    int u, s;
    u = int'(a) + int'(b) + int'(c);
    s = (a ? -1 : 0) + (b ? -1 : 0) + int'(c);
    return {(s > 0 || s < -1), u[1:0]};
  endfunction

  logic       m8_v = 1'b0, m8_co = 1'b0, m8_ovf = 1'b0;
  logic [7:0] m8_res = '0;
  logic       m1_v = 1'b0, m1_co = 1'b0, m1_ovf = 1'b0;
  logic [0:0] m1_res = '0;

  // Model state follows the behavioural rules: capture on valid, hold otherwise, async clear.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_v <= 1'b0; m8_res <= '0; m8_co <= 1'b0; m8_ovf <= 1'b0;
      m1_v <= 1'b0; m1_res <= '0; m1_co <= 1'b0; m1_ovf <= 1'b0;
    end else begin
      m8_v <= iv;
      m1_v <= iv;
      if (iv) begin
        {m8_ovf, m8_co, m8_res} <= model8(a8, b8, c8);
        {m1_ovf, m1_co, m1_res} <= model1(a1[0], b1[0], c1);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];   // literal expectations for u8: {ovf, co, result}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("u8_out_valid", 64'(u8_ov), 64'(m8_v));
    check("u8_result", 64'(u8_res), 64'(m8_res));
    check("u8_carry_out", 64'(u8_co), 64'(m8_co));
    check("u1_out_valid", 64'(u1_ov), 64'(m1_v));
    check("u1_result", 64'(u1_res), 64'(m1_res));
    check("u1_carry_out", 64'(u1_co), 64'(m1_co));
`ifdef FULL_ADDER_OVF_EN
    check("u8_overflow", 64'(u8_ovf), 64'(m8_ovf));
    check("u1_overflow", 64'(u1_ovf), 64'(m1_ovf));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_u8_ov"}, 64'(u8_ov), 64'd0);
    check({tag, "_u8_res"}, 64'(u8_res), 64'd0);
    check({tag, "_u8_co"}, 64'(u8_co), 64'd0);
    check({tag, "_u1_ov"}, 64'(u1_ov), 64'd0);
    check({tag, "_u1_res"}, 64'(u1_res), 64'd0);
    check({tag, "_u1_co"}, 64'(u1_co), 64'd0);
`ifdef FULL_ADDER_OVF_EN
    check({tag, "_u8_ovf"}, 64'(u8_ovf), 64'd0);
    check({tag, "_u1_ovf"}, 64'(u1_ovf), 64'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        input logic ya, input logic yb, input logic yc);
    iv = v; a8 = xa; b8 = xb; c8 = xc; a1[0] = ya; b1[0] = yb; c1 = yc;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop one literal u8 expectation and compare it with the current outputs.
  task automatic pop_check8(input string name);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_ov"}, 64'(u8_ov), 64'd1);
      check({name, "_res"}, 64'(u8_res), 64'(e[7:0]));
      check({name, "_co"}, 64'(u8_co), 64'(e[8]));
`ifdef FULL_ADDER_OVF_EN
      check({name, "_ovf"}, 64'(u8_ovf), 64'(e[9]));
`endif
    end
  endtask

  // ---------------- directed vectors ----------------
  // WIDTH=8: {a, b, cin} and literal {ovf, co, result}.
  logic [16:0] v8_in [8] = '{
    {8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1}, {8'h00, 8'h00, 1'b0}, {8'h7F, 8'h01, 1'b0},
    {8'h80, 8'h80, 1'b0}, {8'h01, 8'h01, 1'b0}, {8'hA5, 8'h5A, 1'b1}, {8'h12, 8'h34, 1'b0}};
  logic [10:0] v8_exp [8] = '{
    {2'b00, 1'b1, 8'h00}, {2'b00, 1'b1, 8'hFF}, {2'b00, 1'b0, 8'h00}, {2'b01, 1'b0, 8'h80},
    {2'b01, 1'b1, 8'h00}, {2'b00, 1'b0, 8'h02}, {2'b00, 1'b1, 8'h00}, {2'b00, 1'b0, 8'h46}};
  // WIDTH=1 truth table, index = {a,b,cin}; value = {result, carry_out}.
  logic [1:0] tt_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    // Compare loop: every falling edge, both instances against the model.
    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    // ---- reset with active-looking inputs ----
    set_in(1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 rst = 1'b1;
    #1 check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      step();
      check_zero("rst_hold");
    end
    rst = 1'b0;

    // ---- truth table at WIDTH=1, boundary vectors at WIDTH=8 ----
    for (int i = 0; i < 8; i++) begin
      logic [2:0] bits;
      bits = 3'(i);
      set_in(1'b1, v8_in[i][16:9], v8_in[i][8:1], v8_in[i][0], bits[2], bits[1], bits[0]);
      exp_q.push_back(v8_exp[i]);
      step();
      check("tt_u1_ov", 64'(u1_ov), 64'd1);
      check("tt_u1_res", 64'(u1_res), 64'(tt_exp[i][1]));
      check("tt_u1_co", 64'(u1_co), 64'(tt_exp[i][0]));
`ifdef FULL_ADDER_OVF_EN
      check("tt_u1_ovf", 64'(u1_ovf), 64'(tt_exp[i][0] ^ bits[0]));
`endif
      pop_check8("vec8");
    end

    // ---- hold: drop valid, change inputs, then drive X ----
    set_in(1'b1, 8'h03, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    set_in(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_u1_res", 64'(u1_res), 64'd1);
      check("hold_u1_co", 64'(u1_co), 64'd0);
      check("hold_u1_ov", 64'(u1_ov), 64'd0);
      check("hold_u8_res", 64'(u8_res), 64'h07);
      check("hold_u8_co", 64'(u8_co), 64'd0);
      a8 = 'x; b8 = 'x; c8 = 1'bx; a1 = 'x; b1 = 'x; c1 = 1'bx;
    end

    // ---- three back-to-back sums, then a reset pulse between edges ----
    set_in(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 1'b0, 8'h30});
    step();
    pop_check8("b2b0");
    set_in(1'b1, 8'hC8, 8'h64, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({2'b00, 1'b1, 8'h2D});
    step();
    pop_check8("b2b1");
    set_in(1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({2'b00, 1'b0, 8'h78});
    step();
    pop_check8("b2b2");
    check("b2b2_u1_res", 64'(u1_res), 64'd1);
    iv = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero("mid_rst");
    #1 rst = 1'b0;
    step();
    check_zero("post_rst");
    set_in(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({2'b00, 1'b0, 8'h10});
    step();
    pop_check8("after_rst");
    check("after_rst_u1_res", 64'(u1_res), 64'd1);
    check("after_rst_u1_co", 64'(u1_co), 64'd1);
    iv = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
